// File: rtl/sd_debug_pkg.sv
// Shared types and helpers for the SD debug path: CMD-line frame layout,
// line-length constants and the nibble-to-ASCII converter.
package sd_debug_pkg;

  // Captured CMD-line frame, bit 47 = start bit
  typedef struct packed {
    logic        sbit;
    logic        tbit;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        stop;
  } sd_cmd_frame_t;

  // The subset of a frame that actually appears in the text line
  typedef struct packed {
    logic        tbit;
    logic [5:0]  cmd;
    logic [31:0] arg;
  } sd_line_src_t;

  typedef enum logic {
    FMT_IDLE,
    FMT_EMIT
  } fmt_state_e;

  // dir + 2 cmd digits + space + 8 arg digits
  localparam int unsigned LINE_BODY_LEN = 12;
  // " !" + 2 drop-count digits
  localparam int unsigned LINE_DROP_LEN = 4;

  // Uppercase ASCII hex digit for one nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end
    return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/sd_cmd_line_formatter.sv
// Renders captured SD CMD-line frames as fixed-length ASCII lines and streams
// them byte-by-byte to the debug UART. A one-entry pending buffer absorbs a
// frame arriving mid-line; anything beyond that is dropped.
// Optional feature macro: SD_FMT_DROPCNT_EN adds a saturating drop counter
// whose value is appended to every line as " !XX".
module sd_cmd_line_formatter
  import sd_debug_pkg::*;
#(
  parameter bit CRLF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_en,
  input  logic [47:0] frame,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        busy
);

`ifdef SD_FMT_DROPCNT_EN
  localparam bit DROP_FIELD_ON = 1'b1;
`else
  localparam bit DROP_FIELD_ON = 1'b0;
`endif

  localparam int unsigned FIELD_LEN = LINE_BODY_LEN + (DROP_FIELD_ON ? LINE_DROP_LEN : 0);
  localparam int unsigned LINE_LEN  = FIELD_LEN + (CRLF_EN ? 2 : 1);
  localparam logic [4:0]  LAST_IDX  = 5'(LINE_LEN - 1);
  localparam logic [4:0]  END_IDX   = 5'(FIELD_LEN);
  localparam logic [4:0]  DROP_IDX  = 5'(LINE_BODY_LEN);

  sd_cmd_frame_t frame_in;
  logic          unused_frame_bits;
  fmt_state_e    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  sd_line_src_t  cur_q, cur_d;
  sd_line_src_t  pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    snap_d;
  logic          xfer;
  logic          accept;
  logic          drop;

  assign frame_in          = sd_cmd_frame_t'(frame);
  assign unused_frame_bits = ^{frame_in.sbit, frame_in.crc, frame_in.stop};

  // Character at position idx of the line built from src (drops only shown
  // when the drop field is compiled in)
  function automatic logic [7:0] line_char(input sd_line_src_t src,
                                           input logic [7:0]   drops,
                                           input logic [4:0]   idx);
    logic [7:0]  ch;
    logic [2:0]  arg_nib;
    logic [31:0] arg_shift;
    ch        = 8'h0A;
    arg_nib   = 3'(4'd11 - idx[3:0]);
    arg_shift = src.arg >> {arg_nib, 2'b00};
    if (idx == 5'd0) begin
      ch = src.tbit ? 8'h48 : 8'h44;
    end else if (idx == 5'd1) begin
      ch = hex_ascii({2'b00, src.cmd[5:4]});
    end else if (idx == 5'd2) begin
      ch = hex_ascii(src.cmd[3:0]);
    end else if (idx == 5'd3) begin
      ch = 8'h20;
    end else if (idx < DROP_IDX) begin
      ch = hex_ascii(arg_shift[3:0]);
    end else if (DROP_FIELD_ON && idx == DROP_IDX) begin
      ch = 8'h20;
    end else if (DROP_FIELD_ON && idx == DROP_IDX + 5'd1) begin
      ch = 8'h21;
    end else if (DROP_FIELD_ON && idx == DROP_IDX + 5'd2) begin
      ch = hex_ascii(drops[7:4]);
    end else if (DROP_FIELD_ON && idx == DROP_IDX + 5'd3) begin
      ch = hex_ascii(drops[3:0]);
    end else if (CRLF_EN && idx == END_IDX) begin
      ch = 8'h0D;
    end
    return ch;
  endfunction

  // Line sequencing and pending-buffer capture; a frame may enter pend in the
  // same cycle the old pend content moves to cur
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    xfer     = (state_q == FMT_IDLE) && pend_v_q;
    accept   = frame_en && (!pend_v_q || xfer);
    drop     = frame_en && !accept;
    case (state_q)
      FMT_IDLE: begin
        if (pend_v_q) begin
          cur_d    = pend_q;
          pend_v_d = 1'b0;
          idx_d    = '0;
          state_d  = FMT_EMIT;
        end
      end
      FMT_EMIT: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = FMT_IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = FMT_IDLE;
    endcase
    if (accept) begin
      pend_d   = '{tbit: frame_in.tbit, cmd: frame_in.cmd, arg: frame_in.arg};
      pend_v_d = 1'b1;
    end
  end

`ifdef SD_FMT_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] cur_drop_q, cur_drop_d;

  // Saturating drop counter, snapshotted into the line and restarted on transfer
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    cur_drop_d = cur_drop_q;
    if (xfer) begin
      cur_drop_d = drop_cnt_q;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      cur_drop_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      cur_drop_q <= cur_drop_d;
    end
  end

  assign snap_d = cur_drop_d;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign snap_d      = 8'h00;
`endif

  // Output byte is computed from next-state so tx_valid/tx_data come straight
  // from flops and hold still while the UART stalls
  always_comb begin
    tx_valid_d = (state_d == FMT_EMIT);
    tx_data_d  = tx_valid_d ? line_char(cur_d, snap_d, idx_d) : 8'h00;
  end

  // State, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FMT_IDLE;
      idx_q      <= '0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = pend_v_q | (state_q == FMT_EMIT);

endmodule
